fpa_align: RTL and testbench
============================

# fpa_align

Operand alignment stage sitting directly upstream of `fpa_adder` in the single-precision FP datapath. It accepts two IEEE-754 binary32 operands and an add/sub select, unpacks them, and applies the operation's sign to `b`. It swaps the operands so the larger magnitude is first, then right-shifts the smaller significand into a guard/round/sticky extended format. It is a 2-stage valid/ready pipeline, so the adder core receives pre-aligned significands and a common exponent.

## Interface
- No parameters; format is fixed to binary32 (8-bit exponent, 23-bit fraction).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  stage accepts a pair this cycle.
- `a`, `b`  in  32  binary32 operands.
- `inp_op`  in  1  0 = a+b, 1 = a−b.
- `out_valid`  out  1  aligned result present.
- `out_ready`  in  1  downstream accepts.
- `sign_big`, `sign_small`  out  1  effective signs; `b`'s sign is already flipped when `inp_op`=1.
- `exp_out`  out  8  biased exponent of the larger operand (denormal reported as 1).
- `mant_big`, `mant_small`  out  27  format [26]=hidden, [25:3]=fraction, [2:0]=G,R,S.
- `eff_sub`  out  1  `sign_big` ≠ `sign_small`.
- `is_nan`, `is_inf`  out  1  special-result flags.
- `inf_sign`  out  1  sign of the infinity result when `is_inf`=1.

## Operation
- Unpack each operand:
  - hidden bit = (exp≠0);
  - effective exponent = exp, or 1 when exp=0;
  - significand = {hidden, frac, 3'b000}.
- Effective `b` sign = `b[31]` XOR `inp_op`.
- Magnitude compare on {eff_exp, frac}. The larger magnitude becomes "big"; on a tie, `a` is big.
- d = exp_big − exp_small (0..254).
- d < 27: `mant_small` = sig_small >> d, and bit 0 is ORed with the OR of all bits shifted out.
- d ≥ 27: `mant_small` = 27'h0000001 if sig_small≠0, else 0.
- Specials:
  - exp=255 with frac≠0 is NaN.
  - exp=255 with frac=0 is Inf.
  - `is_nan` = either input NaN, OR both Inf with `eff_sub`=1.
  - `is_inf` = (any Inf) AND NOT `is_nan`. `inf_sign` = effective sign of an infinite operand (`a` first).
  - The numeric outputs follow the normal path regardless; the consumer prioritises the flags.
- Stage 1 register: unpack, sign fix, compare/swap, d. Stage 2 register: barrel shift with sticky, flags.

## Timing
- Latency: 2 cycles from the accepting edge (`in_valid`&`in_ready`) to `out_valid`.
- Throughput: 1 pair/cycle when `out_ready`=1.
- Handshake, with stall-pipeline semantics:
  - adv2 = !v2 | `out_ready`;
  - adv1 = !v1 | adv2;
  - `in_ready` = adv1.
  - `in_ready` combinationally depends on `out_ready`, by design.
- While `out_valid`=1 and `out_ready`=0, all outputs hold stable. No pair is dropped or duplicated.
- `out_valid` may not depend on `out_ready`.
- Reset: while `rst_n`=0 at a clock edge, both valid bits clear and all data outputs go to 0.
  - Reset asserted mid-stream discards in-flight pairs.
  - `in_ready`=1 in the first cycle after release.
- Simultaneous accept and emit in one cycle is legal and required for full throughput.

## Structure
- Package `fpa_pkg`: constants EXP_W=8, FRAC_W=23, MANT_W=27, EXP_MAX=8'hFF; a struct/typedef for an unpacked operand (sign, exp, sig, is_nan, is_inf).
- One sub-module, `fpa_rshift_sticky` (27-bit data, 8-bit amount → shifted value with sticky folded into bit 0). It is reused later by the normaliser.

## Test plan
- a=0x40DFAC71, b=0x4476B996, op=0 → after 2 cycles: `exp_out`=136, `mant_big`=27'h7B5CCB0, `mant_small`=27'h00DFAC7, `eff_sub`=0, flags 0.
- a=0x3F800000, b=0x30800000, op=0 (d=30) → `mant_small`=27'h0000001, `exp_out`=127.
- a=b=0x40DFAC71, op=1 → a is big, `eff_sub`=1, `mant_big`=`mant_small`=27'h6FD6388, `sign_small`=1.
- a=0x7F800000, b=0x7F800000, op=1 → `is_nan`=1, `is_inf`=0. Same pair with op=0 → `is_inf`=1, `inf_sign`=0.
- `out_ready`=0 while 3 pairs are offered:
  - 2 are accepted, then `in_ready`=0.
  - Outputs stay stable.
  - After releasing `out_ready`, all 3 pairs emerge in order, each exactly once.
- Assert `rst_n`=0 with both stages full → the next cycle has `out_valid`=0, outputs 0, `in_ready`=1. A fresh pair then emerges after 2 cycles.

Source files
------------

// File: rtl/fpa_pkg.sv
// Shared binary32 constants and the unpacked-operand type for the FP datapath.
package fpa_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 27;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] sig;
    logic              is_nan;
    logic              is_inf;
  } operand_t;

  // Denormals take exponent 1 and a zero hidden bit so they line up with normals.
  function automatic operand_t unpack(input logic [31:0] x, input logic flip);
    operand_t o;
    o.sign   = x[31] ^ flip;
    o.exp    = (x[30:23] == '0) ? 8'd1 : x[30:23];
    o.sig    = {(x[30:23] != '0), x[22:0], 3'b000};
    o.is_nan = (x[30:23] == EXP_MAX) && (x[22:0] != '0);
    o.is_inf = (x[30:23] == EXP_MAX) && (x[22:0] == '0);
    return o;
  endfunction
endpackage

// File: rtl/fpa_rshift_sticky.sv
// Right shift of a 27-bit significand with every bit shifted out folded into bit 0.
module fpa_rshift_sticky
  import fpa_pkg::*;
(
  input  logic [MANT_W-1:0] data_i,
  input  logic [EXP_W-1:0]  amt_i,
  output logic [MANT_W-1:0] data_o
);
  logic [MANT_W-1:0] stage_w [0:5];

  assign stage_w[0] = data_i;

  // Each binary stage ORs its own lost bits into bit 0; later stages carry that sticky along.
  for (genvar gi = 0; gi < 5; gi++) begin : g_stage
    localparam int SH = 1 << gi;
    logic sticky;
    assign sticky = |stage_w[gi][SH-1:0];
    assign stage_w[gi+1] = amt_i[gi]
      ? ((stage_w[gi] >> SH) | {{(MANT_W-1){1'b0}}, sticky})
      : stage_w[gi];
  end

  assign data_o = (|amt_i[7:5]) ? {{(MANT_W-1){1'b0}}, |data_i} : stage_w[5];
endmodule

// File: rtl/fpa_align.sv
// Two-stage operand alignment ahead of the FP adder: unpack/compare/swap, then shift and flag.
module fpa_align
  import fpa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  input  logic              inp_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_big,
  output logic              sign_small,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_big,
  output logic [MANT_W-1:0] mant_small,
  output logic              eff_sub,
  output logic              is_nan,
  output logic              is_inf,
  output logic              inf_sign
);
  logic v1_q, v2_q, adv1, adv2;

  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  // Stage 1: unpack, sign fix, magnitude compare and swap.
  operand_t op_a, op_b, big_d;
  logic a_big_d;
  logic small_sign_d, small_nan_d, small_inf_d;
  logic [MANT_W-1:0] small_sig_d;
  logic [EXP_W-1:0] dist_d;

  assign op_a    = unpack(a, 1'b0);
  assign op_b    = unpack(b, inp_op);
  assign a_big_d = {op_a.exp, op_a.sig[25:3]} >= {op_b.exp, op_b.sig[25:3]};

  always_comb begin
    big_d        = op_a;
    small_sign_d = op_b.sign;
    small_sig_d  = op_b.sig;
    small_nan_d  = op_b.is_nan;
    small_inf_d  = op_b.is_inf;
    dist_d       = op_a.exp - op_b.exp;
    if (!a_big_d) begin
      big_d        = op_b;
      small_sign_d = op_a.sign;
      small_sig_d  = op_a.sig;
      small_nan_d  = op_a.is_nan;
      small_inf_d  = op_a.is_inf;
      dist_d       = op_b.exp - op_a.exp;
    end
  end

  operand_t big_q;
  logic a_big_q, small_sign_q, small_nan_q, small_inf_q;
  logic [MANT_W-1:0] small_sig_q;
  logic [EXP_W-1:0] dist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      big_q        <= '0;
      a_big_q      <= 1'b0;
      small_sign_q <= 1'b0;
      small_sig_q  <= '0;
      small_nan_q  <= 1'b0;
      small_inf_q  <= 1'b0;
      dist_q       <= '0;
    end else begin
      if (adv1) v1_q <= in_valid;
      if (adv1 && in_valid) begin
        big_q        <= big_d;
        a_big_q      <= a_big_d;
        small_sign_q <= small_sign_d;
        small_sig_q  <= small_sig_d;
        small_nan_q  <= small_nan_d;
        small_inf_q  <= small_inf_d;
        dist_q       <= dist_d;
      end
    end
  end

  // Stage 2: alignment shift and special-value flags.
  logic [MANT_W-1:0] shifted_w;
  logic nan_d, inf_d, inf_sign_d, a_inf, a_sign, b_sign;

  fpa_rshift_sticky u_rshift (
    .data_i (small_sig_q),
    .amt_i  (dist_q),
    .data_o (shifted_w)
  );

  assign nan_d = big_q.is_nan || small_nan_q ||
                 (big_q.is_inf && small_inf_q && (big_q.sign != small_sign_q));
  assign inf_d = (big_q.is_inf || small_inf_q) && !nan_d;
  // The infinity sign prefers operand a, so undo the swap here.
  assign a_inf      = a_big_q ? big_q.is_inf : small_inf_q;
  assign a_sign     = a_big_q ? big_q.sign   : small_sign_q;
  assign b_sign     = a_big_q ? small_sign_q : big_q.sign;
  assign inf_sign_d = inf_d && (a_inf ? a_sign : b_sign);

  logic sign_big_q, sign_small_q, eff_sub_q, is_nan_q, is_inf_q, inf_sign_q;
  logic [EXP_W-1:0] exp_q;
  logic [MANT_W-1:0] mant_big_q, mant_small_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2_q         <= 1'b0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      exp_q        <= '0;
      mant_big_q   <= '0;
      mant_small_q <= '0;
      eff_sub_q    <= 1'b0;
      is_nan_q     <= 1'b0;
      is_inf_q     <= 1'b0;
      inf_sign_q   <= 1'b0;
    end else begin
      if (adv2) v2_q <= v1_q;
      if (adv2 && v1_q) begin
        sign_big_q   <= big_q.sign;
        sign_small_q <= small_sign_q;
        exp_q        <= big_q.exp;
        mant_big_q   <= big_q.sig;
        mant_small_q <= shifted_w;
        eff_sub_q    <= big_q.sign ^ small_sign_q;
        is_nan_q     <= nan_d;
        is_inf_q     <= inf_d;
        inf_sign_q   <= inf_sign_d;
      end
    end
  end

  assign out_valid  = v2_q;
  assign sign_big   = sign_big_q;
  assign sign_small = sign_small_q;
  assign exp_out    = exp_q;
  assign mant_big   = mant_big_q;
  assign mant_small = mant_small_q;
  assign eff_sub    = eff_sub_q;
  assign is_nan     = is_nan_q;
  assign is_inf     = is_inf_q;
  assign inf_sign   = inf_sign_q;
endmodule

// File: tb/tb_fpa_align.sv
// Directed-vector bench for fpa_align with an arithmetic reference model and in-order scoreboard.
module tb_fpa_align;
  typedef struct packed {
    logic        sb;
    logic        ss;
    logic [7:0]  ex;
    logic [26:0] mb;
    logic [26:0] ms;
    logic        es;
    logic        nan;
    logic        inf;
    logic        isg;
  } rec_t;

  logic clk, rst_n, in_valid, in_ready, inp_op, out_valid, out_ready;
  logic [31:0] a, b;
  logic sign_big, sign_small, eff_sub, is_nan, is_inf, inf_sign;
  logic [7:0] exp_out;
  logic [26:0] mant_big, mant_small;
  rec_t dut_rec;

  fpa_align dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .inp_op(inp_op), .out_valid(out_valid), .out_ready(out_ready),
    .sign_big(sign_big), .sign_small(sign_small), .exp_out(exp_out),
    .mant_big(mant_big), .mant_small(mant_small), .eff_sub(eff_sub),
    .is_nan(is_nan), .is_inf(is_inf), .inf_sign(inf_sign)
  );

  assign dut_rec = {sign_big, sign_small, exp_out, mant_big, mant_small,
                    eff_sub, is_nan, is_inf, inf_sign};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pushes   = 0;
  rec_t exp_q[$];
  rec_t got_log[$];

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the binary32 fields.
  function automatic rec_t model(input logic [31:0] x, input logic [31:0] y, input logic op);
    rec_t r;
    int ex, ey, xa, xb, d, big_e;
    longint fa, fb, siga, sigb, big_sig, small_sig, scale;
    bit sa, sb, a_big, nx, ny, ix, iy;
    ex = int'(x[30:23]);  ey = int'(y[30:23]);
    fa = longint'(x[22:0]); fb = longint'(y[22:0]);
    sa = x[31]; sb = y[31] ^ op;
    xa = (ex == 0) ? 1 : ex;
    xb = (ey == 0) ? 1 : ey;
    siga = ((ex != 0) ? 64'd8388608 : 64'd0) + fa;
    sigb = ((ey != 0) ? 64'd8388608 : 64'd0) + fb;
    siga = siga * 8; sigb = sigb * 8;
    a_big = (xa > xb) || (xa == xb && fa >= fb);
    big_sig   = a_big ? siga : sigb;
    small_sig = a_big ? sigb : siga;
    big_e     = a_big ? xa : xb;
    d         = a_big ? xa - xb : xb - xa;
    r.sb = a_big ? sa : sb;
    r.ss = a_big ? sb : sa;
    r.ex = 8'(big_e);
    r.mb = 27'(big_sig);
    if (d >= 27) r.ms = (small_sig != 0) ? 27'd1 : 27'd0;
    else begin
      scale = longint'(1) << d;
      r.ms = 27'((small_sig / scale) | ((small_sig % scale) != 0 ? 64'd1 : 64'd0));
    end
    r.es = r.sb ^ r.ss;
    nx = (ex == 255) && (fa != 0); ix = (ex == 255) && (fa == 0);
    ny = (ey == 255) && (fb != 0); iy = (ey == 255) && (fb == 0);
    r.nan = nx || ny || (ix && iy && (sa != sb));
    r.inf = (ix || iy) && !r.nan;
    r.isg = r.inf && (ix ? sa : sb);
    return r;
  endfunction

  // Compare process: everything is stable at the falling edge, and what is seen here
  // is exactly what the next rising edge will act on.
  bit   held = 0;
  rec_t held_rec;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held = 0;
    end else begin
      if (held) begin
        check("hold_valid", 68'(out_valid), 68'd1);
        check("hold_data", dut_rec, held_rec);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_output: got %h, required none", dut_rec);
        end else check("stream", dut_rec, exp_q.pop_front());
        got_log.push_back(dut_rec);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, inp_op));
        pushes++;
      end
      held = out_valid && !out_ready;
      held_rec = dut_rec;
    end
  end

  logic [31:0] va [0:11] = '{32'h40DFAC71, 32'h3F800000, 32'h40DFAC71, 32'h7F800000,
                             32'h7F800000, 32'h00000003, 32'hC1200000, 32'h7F000000,
                             32'h7FC00000, 32'h3F800000, 32'h3F800001, 32'h00000000};
  logic [31:0] vb [0:11] = '{32'h4476B996, 32'h30800000, 32'h40DFAC71, 32'h7F800000,
                             32'h7F800000, 32'h00800001, 32'h41200000, 32'h00000000,
                             32'h3F800000, 32'hFF800000, 32'h42000003, 32'h80000000};
  logic       vop [0:11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic set_pair(input int i);
    a = va[i]; b = vb[i]; inp_op = vop[i];
  endtask

  // Offer a pair until it is accepted; returns just after the accepting edge.
  task automatic send(input int i);
    bit ok;
    int n = 0;
    set_pair(i);
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
      n++;
      if (n > 50) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: pair %0d not accepted, required accept", i);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk); n++;
    end
    check("drain_empty", 68'(exp_q.size()), 68'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; inp_op = 1'b0;

    // Pin the model against hand-computed values.
    check("model_v0", model(32'h40DFAC71, 32'h4476B996, 1'b0),
          rec_t'{1'b0, 1'b0, 8'd136, 27'h7B5CCB0, 27'h00DFAC7, 1'b0, 1'b0, 1'b0, 1'b0});
    check("model_v1", model(32'h3F800000, 32'h30800000, 1'b0),
          rec_t'{1'b0, 1'b0, 8'd127, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 68'(out_valid), 68'd0);
    check("reset_in_ready", 68'(in_ready), 68'd1);
    check("reset_data", dut_rec, 68'd0);
    @(posedge clk); #1;

    // Latency from an empty pipeline.
    send(0);
    @(negedge clk); check("latency_1cyc", 68'(out_valid), 68'd0);
    @(negedge clk); check("latency_2cyc", 68'(out_valid), 68'd1);
    @(posedge clk); #1;

    for (int i = 1; i < 12; i++) send(i);
    drain();

    if (got_log.size() >= 5) begin
      check("vec0_lit", got_log[0],
            rec_t'{1'b0, 1'b0, 8'd136, 27'h7B5CCB0, 27'h00DFAC7, 1'b0, 1'b0, 1'b0, 1'b0});
      check("vec1_lit", got_log[1],
            rec_t'{1'b0, 1'b0, 8'd127, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0});
      check("vec2_lit", got_log[2],
            rec_t'{1'b0, 1'b1, 8'd129, 27'h6FD6388, 27'h6FD6388, 1'b1, 1'b0, 1'b0, 1'b0});
      check("inf_sub_lit", got_log[3],
            rec_t'{1'b0, 1'b1, 8'd255, 27'h4000000, 27'h4000000, 1'b1, 1'b1, 1'b0, 1'b0});
      check("inf_add_lit", got_log[4],
            rec_t'{1'b0, 1'b0, 8'd255, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b1, 1'b0});
    end else begin
      n_checks++; n_fail++;
      $display("FAIL log_size: got %0d outputs, required at least 5", got_log.size());
    end

    // Backpressure: three pairs offered with the consumer stalled.
    out_ready = 1'b0;
    acc = 0;
    set_pair(6); in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
      if (acc < 3) set_pair(6 + acc);
    end
    check("stall_accepts", 68'(acc), 68'd2);
    @(negedge clk);
    check("stall_in_ready", 68'(in_ready), 68'd0);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    send(8);
    drain();
    check("once_each", 68'(got_log.size()), 68'(pushes));

    // Reset with both stages full.
    out_ready = 1'b0;
    send(9);
    send(10);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 68'(out_valid), 68'd0);
    check("midrst_data", dut_rec, 68'd0);
    check("midrst_in_ready", 68'(in_ready), 68'd1);
    @(posedge clk); #1;
    send(11);
    @(negedge clk); check("post_rst_lat1", 68'(out_valid), 68'd0);
    @(negedge clk); check("post_rst_lat2", 68'(out_valid), 68'd1);
    @(posedge clk); #1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
